// File: rtl/mibus_slave_rx.sv
// mibus_slave_rx: receiving end of an MIBus link.
// Words from the master are buffered in a show-ahead FIFO and presented
// downstream on a valid/ready stream. Because MIBus carries no ready signal,
// a registered hysteresis throttle (mib_ctrl_flag) holds the master off early
// enough that the SKID words still in flight always find a free slot.
module mibus_slave_rx #(
  parameter int WIDTH   = 64,
  parameter int DEPTH   = 8,
  parameter int SKID    = 2,
  parameter int LO_MARK = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           mib_data,
  input  logic                       mib_valid,
  output logic                       mib_ctrl_flag,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow_err,
  input  logic                       clr_err
);

  localparam int PW      = $clog2(DEPTH);
  localparam int LW      = PW + 1;
  localparam int HI_MARK = DEPTH - SKID;

  // Throttle FSM encoding
  localparam logic [0:0] ST_OPEN     = 1'b0;
  localparam logic [0:0] ST_THROTTLE = 1'b1;

  // Storage has no reset: only entries between rd and wr pointers are ever read
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             err_q, err_d;
  logic [0:0]       state_q, state_d;

  logic             full;
  logic             push;
  logic             pop;
  logic             drop;
  logic [LW-1:0]    level_after_pop;
  logic [PW-1:0]    head_ptr;

  assign full = (level_q == LW'(DEPTH));
  assign pop  = out_valid_q && out_ready;
  // A full FIFO can still take a word when the head leaves in the same cycle
  assign push = mib_valid && (!full || pop);
  assign drop = mib_valid && full && !pop;

  // Occupancy and pointer bookkeeping
  always_comb begin
    level_d  = level_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Next head-of-FIFO word: the incoming word when the FIFO would otherwise be
  // empty, else the stored entry at the (possibly advanced) read pointer.
  // mib_data is only looked at under push, so idle X never reaches out_data.
  always_comb begin
    level_after_pop = level_q - LW'(pop);
    head_ptr        = rd_ptr_q + PW'(pop);
    out_data_d      = '0;
    out_valid_d     = (level_d != '0);
    if (level_after_pop == '0) begin
      if (push) begin
        out_data_d = mib_data;
      end
    end else begin
      out_data_d = mem_q[head_ptr];
    end
  end

  // Sticky overflow flag; a new drop wins over a simultaneous clear
  always_comb begin
    err_d = err_q;
    if (drop) begin
      err_d = 1'b1;
    end else if (clr_err) begin
      err_d = 1'b0;
    end
  end

  // Hysteresis throttle, decided on the occupancy that will exist after this edge
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_OPEN: begin
        if (level_d >= LW'(HI_MARK)) begin
          state_d = ST_THROTTLE;
        end
      end
      default: begin
        if (level_d <= LW'(LO_MARK)) begin
          state_d = ST_OPEN;
        end
      end
    endcase
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= mib_data;
    end
  end

  // Control state registers; reset holds the master off
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      state_q     <= ST_THROTTLE;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      state_q     <= state_d;
    end
  end

  assign mib_ctrl_flag = (state_q == ST_THROTTLE);
  assign out_data      = out_data_q;
  assign out_valid     = out_valid_q;
  assign level         = level_q;
  assign overflow_err  = err_q;

endmodule

// File: tb/tb_mibus_slave_rx.sv
// Directed bench for mibus_slave_rx: reset, single word, fill to full with
// throttle, overflow/clear, drain with hysteresis, full push+pop and async reset.
module tb_mibus_slave_rx;

  localparam int WIDTH = 64;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] mib_data;
  logic             mib_valid;
  logic             mib_ctrl_flag;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       level;
  logic             overflow_err;
  logic             clr_err;

  int errors = 0;
  int checks = 0;

  mibus_slave_rx #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SKID(2), .LO_MARK(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .mib_data     (mib_data),
    .mib_valid    (mib_valid),
    .mib_ctrl_flag(mib_ctrl_flag),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .level        (level),
    .overflow_err (overflow_err),
    .clr_err      (clr_err)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; mib_valid = 1'b0; mib_data = 'x; out_ready = 1'b0; clr_err = 1'b0;
    repeat (3) step();
    checks++; if (mib_ctrl_flag !== 1'b1) begin errors++; $display("FAIL rst_flag: got %b exp 1", mib_ctrl_flag); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b exp 0", out_valid); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL rst_level: got %0d exp 0", level); end
    checks++; if (out_data !== 64'd0) begin errors++; $display("FAIL rst_data: got %h exp 0", out_data); end
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b exp 0", overflow_err); end
    rst = 1'b0;
    step();
    checks++; if (mib_ctrl_flag !== 1'b0) begin errors++; $display("FAIL rel_flag: got %b exp 0", mib_ctrl_flag); end
    checks++; if (out_valid !== 1'b0 || level !== 4'd0) begin errors++; $display("FAIL rel_empty: got valid=%b level=%0d exp 0/0", out_valid, level); end
    $display("reset done");
  endtask

  task automatic test_single();
    mib_data = 64'hDEAD_BEEF_0000_0001; mib_valid = 1'b1; out_ready = 1'b1;
    step();
    mib_valid = 1'b0; mib_data = 'x;
    $display("push %h", 64'hDEAD_BEEF_0000_0001);
    checks++; if (out_valid !== 1'b1 || out_data !== 64'hDEAD_BEEF_0000_0001) begin errors++; $display("FAIL single_head: got valid=%b data=%h exp 1/deadbeef00000001", out_valid, out_data); end
    checks++; if (level !== 4'd1) begin errors++; $display("FAIL single_level: got %0d exp 1", level); end
    step();
    checks++; if (out_valid !== 1'b0 || level !== 4'd0) begin errors++; $display("FAIL single_pop: got valid=%b level=%0d exp 0/0", out_valid, level); end
    out_ready = 1'b0;
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      mib_data = 64'(i); mib_valid = 1'b1;
      step();
      $display("push %0d level=%0d flag=%b", i, level, mib_ctrl_flag);
      checks++; if (level !== 4'(i)) begin errors++; $display("FAIL fill_level%0d: got %0d exp %0d", i, level, i); end
      checks++; if (mib_ctrl_flag !== (i >= 6)) begin errors++; $display("FAIL fill_flag%0d: got %b exp %b", i, mib_ctrl_flag, (i >= 6)); end
    end
    mib_valid = 1'b0; mib_data = 'x;
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL fill_err: got %b exp 0", overflow_err); end
    checks++; if (out_data !== 64'd1) begin errors++; $display("FAIL fill_head: got %h exp 1", out_data); end
  endtask

  task automatic test_overflow();
    mib_data = 64'd9; mib_valid = 1'b1;
    step();
    mib_valid = 1'b0;
    $display("push 9 (full)");
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b exp 1", overflow_err); end
    checks++; if (level !== 4'd8 || out_data !== 64'd1) begin errors++; $display("FAIL ovf_hold: got level=%0d data=%h exp 8/1", level, out_data); end
    mib_data = 64'd10; mib_valid = 1'b1; clr_err = 1'b1;
    step();
    mib_valid = 1'b0;
    checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_setwins: got %b exp 1", overflow_err); end
    step();
    clr_err = 1'b0;
    checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b exp 0", overflow_err); end
    checks++; if (level !== 4'd8) begin errors++; $display("FAIL ovf_level: got %0d exp 8", level); end
  endtask

  task automatic test_drain();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== 64'(i)) begin errors++; $display("FAIL drain_data%0d: got valid=%b data=%h exp 1/%h", i, out_valid, out_data, 64'(i)); end
      step();
      $display("pop %0d level=%0d flag=%b", i, level, mib_ctrl_flag);
      checks++; if (level !== 4'(8 - i)) begin errors++; $display("FAIL drain_level%0d: got %0d exp %0d", i, level, 8 - i); end
      checks++; if (mib_ctrl_flag !== ((8 - i) > 2)) begin errors++; $display("FAIL drain_flag%0d: got %b exp %b", i, mib_ctrl_flag, ((8 - i) > 2)); end
    end
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b exp 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      mib_data = 64'(11 + i); mib_valid = 1'b1;
      step();
    end
    checks++; if (level !== 4'd8) begin errors++; $display("FAIL b2b_full: got %0d exp 8", level); end
    for (int k = 0; k < 3; k++) begin
      mib_data = 64'(19 + k); mib_valid = 1'b1; out_ready = 1'b1;
      checks++; if (out_data !== 64'(11 + k)) begin errors++; $display("FAIL b2b_head%0d: got %h exp %h", k, out_data, 64'(11 + k)); end
      step();
      $display("push %0d pop %0d level=%0d", 19 + k, 11 + k, level);
      checks++; if (level !== 4'd8 || overflow_err !== 1'b0) begin errors++; $display("FAIL b2b_level%0d: got level=%0d err=%b exp 8/0", k, level, overflow_err); end
    end
    #3;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || level !== 4'd0) begin errors++; $display("FAIL arst_empty: got valid=%b level=%0d exp 0/0", out_valid, level); end
    checks++; if (mib_ctrl_flag !== 1'b1 || out_data !== 64'd0) begin errors++; $display("FAIL arst_flag: got flag=%b data=%h exp 1/0", mib_ctrl_flag, out_data); end
    step();
    mib_valid = 1'b0; out_ready = 1'b0; mib_data = 'x;
    rst = 1'b0;
    step();
    checks++; if (mib_ctrl_flag !== 1'b0 || level !== 4'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL arst_rel: got flag=%b level=%0d valid=%b exp 0/0/0", mib_ctrl_flag, level, out_valid); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_overflow();
    test_drain();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
